imem_read_responder: RTL and testbench
======================================

// Module: imem_read_responder
// PURPOSE
//  Memory-side responder for the instruction-cache refill interface. Serves single-word
//  read requests from an on-chip word array, with a programmable wait-state latency.
//  Sits between the I-cache memory port and the instruction BRAM. Also provides a
//  write-only load port for program preload and debug writes.
// PARAMETERS
//  MEM_DEPTH     1024  words in the array; power of two; AW = $clog2(MEM_DEPTH)
//  READ_LATENCY  2     cycles from request acceptance to response pulse; legal range 1..15
//  INIT_FILE     ""    $readmemh image loaded at elaboration; empty string = no init
// PORTS
//  clk                 in   1   clock
//  rst_n               in   1   synchronous, active-low reset
//  mem_read_request    in   1   level; held by the cache until it sees the response or a flush abort
//  mem_addr            in   32  byte address; bits [AW+1:2] select the word, [1:0] ignored
//  mem_read_response   out  1   one-cycle pulse; mem_read_data is valid in this cycle
//  mem_read_data       out  32  read word
//  busy                out  1   high while in WAIT or RESP
//  load_we             in   1   write strobe, accepted in any state
//  load_addr           in   32  byte address for the write, same decoding as mem_addr
//  load_data           in   32  write data
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=IDLE, mem_read_response=0, mem_read_data=0,
//    busy=0, counter=0. Array contents are kept (not cleared).
//  - FSM:
//    - IDLE: request sampled high at an edge -> latch word index, counter=READ_LATENCY-1.
//      Next state is RESP if READ_LATENCY==1, otherwise WAIT.
//    - WAIT: counter decrements each edge; when counter==1 the next state is RESP.
//    - RESP: response=1 for exactly one cycle; next state is always IDLE.
//  - Latency: request first sampled high at edge E0 -> response high in the cycle after
//    edge E0+READ_LATENCY-1, i.e. READ_LATENCY cycles after acceptance.
//  - Back-to-back requests: a new request cannot be accepted before the IDLE cycle that
//    follows RESP. The request level present during RESP is ignored; this stops the
//    just-served request from being accepted twice. Minimum spacing is READ_LATENCY+1.
//  - Array read: happens on the edge that enters RESP, using the latched index;
//    mem_read_data is registered.
//  - mem_read_data holds its last value outside RESP.
//  - Abort: if the request drops during WAIT (cache flush), the transaction still
//    completes and pulses response; the cache discards that pulse. A transaction is
//    never cancelled. mem_addr changes after acceptance are ignored.
//  - Load write: array[load_addr[AW+1:2]] <= load_data on any edge with load_we=1
//    (reset not required). If a write and the RESP-entry read hit the same word on the
//    same edge, the read returns the old data. Writes on earlier edges are visible.
//  - Address bits above AW+1 are ignored (wrap modulo MEM_DEPTH) unless the macro below is set.
//  - Reset asserted during WAIT or RESP: the transaction is dropped and no response is issued.
// CONFIGURATION
//  IMEM_ADDR_CHECK_EN defined:
//    - Adds output mem_read_error (1 bit, reset 0), which pulses together with the response.
//    - A latched address with any bit [31:AW+2] set returns 32'h0000_0013 (NOP) and
//      mem_read_error=1.
//    - Load writes to out-of-range addresses are dropped.
//  IMEM_ADDR_CHECK_EN undefined:
//    - No mem_read_error port; all addresses wrap; no error handling logic.
// TESTING
//  1. Preload [0x10]=0xDEADBEEF, LAT=2, request at edge 0 held ->
//     response pulse only in the cycle after edge 1, data=0xDEADBEEF.
//  2. LAT=1, req to 0x0 then 0x4 after each response (request held through RESP) ->
//     each response pulses exactly once, spacing 2 cycles, correct data.
//  3. LAT=4, drop request 1 cycle after acceptance ->
//     response still pulses at cycle 4; FSM returns to IDLE, no second pulse.
//  4. load_we to 0x20 with 0x12345678 on the RESP-entry edge of a read to 0x20 ->
//     old data returned; the next read returns 0x12345678.
//  5. rst_n low during WAIT -> no response; response=0, data=0, busy=0;
//     preload contents intact on a later read.
//  6. MEM_DEPTH=1024, read 0x0000_1004:
//     - with IMEM_ADDR_CHECK_EN: data 0x00000013 and error=1;
//     - without it: data of word 1.

Source files
------------

// File: rtl/imem_read_responder.sv
// imem_read_responder: single-word read responder for the I-cache refill port,
// backed by an on-chip word array with a programmable wait-state latency and a
// write-only load port for preload/debug writes.
// Optional feature macro: IMEM_ADDR_CHECK_EN (out-of-range address detection,
// adds mem_read_error; reads return a NOP word, writes are dropped).
module imem_read_responder #(
  parameter int unsigned MEM_DEPTH    = 1024,
  parameter int unsigned READ_LATENCY = 2,
  parameter string       INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_request,
  input  logic [31:0] mem_addr,
  output logic        mem_read_response,
  output logic [31:0] mem_read_data,
  output logic        busy,
`ifdef IMEM_ADDR_CHECK_EN
  output logic        mem_read_error,
`endif
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int unsigned AW     = $clog2(MEM_DEPTH);
  localparam logic [3:0]  LAT_M1 = 4'(READ_LATENCY - 1);
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    count_q;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] rd_idx;
  logic          accept;
  logic          enter_resp;
  logic [31:0]   mem [MEM_DEPTH];

  assign accept     = (state_q == S_IDLE) && mem_read_request;
  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

  // With a latency of 1 the array is read on the acceptance edge itself, before
  // idx_q has been loaded, so the index is taken straight from mem_addr there.
  assign rd_idx = (state_q == S_IDLE) ? mem_addr[AW+1:2] : idx_q;

  assign mem_read_response = (state_q == S_RESP);
  assign busy              = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mem_read_request) state_d = (READ_LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT:  if (count_q == 4'd1) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef IMEM_ADDR_CHECK_EN
  logic oob_q;
  logic rd_oob;
  logic wr_oob;

  assign rd_oob = (state_q == S_IDLE) ? (|mem_addr[31:AW+2]) : oob_q;
  assign wr_oob = |load_addr[31:AW+2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oob_q          <= 1'b0;
      mem_read_error <= 1'b0;
    end else begin
      if (accept) oob_q <= |mem_addr[31:AW+2];
      mem_read_error <= enter_resp && rd_oob;
    end
  end
`else
  logic rd_oob;
  logic wr_oob;

  assign rd_oob = 1'b0;
  assign wr_oob = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q       <= '0;
      idx_q         <= '0;
      mem_read_data <= '0;
    end else begin
      if (accept) begin
        count_q <= LAT_M1;
        idx_q   <= mem_addr[AW+1:2];
      end else if (state_q == S_WAIT) begin
        count_q <= count_q - 4'd1;
      end
      if (enter_resp) mem_read_data <= rd_oob ? NOP : mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (load_we && !wr_oob) mem[load_addr[AW+1:2]] <= load_data;
  end

  logic unused_bits;
`ifdef IMEM_ADDR_CHECK_EN
  assign unused_bits = &{1'b0, mem_addr[1:0], load_addr[1:0]};
`else
  assign unused_bits = &{1'b0, mem_addr[1:0], load_addr[1:0],
                         mem_addr[31:AW+2], load_addr[31:AW+2]};
`endif

endmodule

// File: tb/tb_imem_read_responder.sv
// Bench for imem_read_responder: three instances (latency 1, 2, 4) sharing the
// load port, checked against a word-array model and the latency rules.
module tb_imem_read_responder;

  localparam int NI  = 3;
  localparam int WIN = 20;

  logic clk;
  logic rst_n;
  logic [NI-1:0]       req;
  logic [NI-1:0][31:0] addr;
  logic [NI-1:0]       resp;
  logic [NI-1:0][31:0] rdata;
  logic [NI-1:0]       bsy;
  logic [NI-1:0]       err;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [1024];
  int          pool [$];

  imem_read_responder #(.MEM_DEPTH(1024), .READ_LATENCY(1), .INIT_FILE("")) u_lat1 (
    .clk(clk), .rst_n(rst_n), .mem_read_request(req[0]), .mem_addr(addr[0]),
    .mem_read_response(resp[0]), .mem_read_data(rdata[0]), .busy(bsy[0]),
`ifdef IMEM_ADDR_CHECK_EN
    .mem_read_error(err[0]),
`endif
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data));

  imem_read_responder #(.MEM_DEPTH(1024), .READ_LATENCY(2), .INIT_FILE("")) u_lat2 (
    .clk(clk), .rst_n(rst_n), .mem_read_request(req[1]), .mem_addr(addr[1]),
    .mem_read_response(resp[1]), .mem_read_data(rdata[1]), .busy(bsy[1]),
`ifdef IMEM_ADDR_CHECK_EN
    .mem_read_error(err[1]),
`endif
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data));

  imem_read_responder #(.MEM_DEPTH(1024), .READ_LATENCY(4), .INIT_FILE("")) u_lat4 (
    .clk(clk), .rst_n(rst_n), .mem_read_request(req[2]), .mem_addr(addr[2]),
    .mem_read_response(resp[2]), .mem_read_data(rdata[2]), .busy(bsy[2]),
`ifdef IMEM_ADDR_CHECK_EN
    .mem_read_error(err[2]),
`endif
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data));

`ifndef IMEM_ADDR_CHECK_EN
  assign err = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic addr_oob(input logic [31:0] a);
`ifdef IMEM_ADDR_CHECK_EN
    return |a[31:12];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    if (addr_oob(a)) return 32'h0000_0013;
    return model_mem[a[11:2]];
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
    logic [9:0] w;
    if (addr_oob(a)) return;
    w = a[11:2];
    model_mem[w] = d;
    foreach (pool[i]) if (pool[i] == int'(w)) return;
    pool.push_back(int'(w));
  endfunction

  function automatic logic [31:0] pool_addr();
    logic [9:0] w;
    logic [1:0] b;
    w = 10'(pool[$urandom_range(0, pool.size() - 1)]);
    b = 2'($urandom);
    return {20'h0, w, b};
  endfunction

  // Preload/debug write through the load port, one edge wide
  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    load_we = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_we = 1'b0;
    model_write(a, d);
  endtask

  // Drives one read on instance k and records what came back; no checking here.
  // drop_c: cycle after acceptance at which the request is dropped (-1 = hold).
  // wr_c: cycle whose following edge carries a load write of wd to wa (-1 = none).
  task automatic run_read(input int k, input logic [31:0] a, input int drop_c,
                          input int wr_c, input logic [31:0] wa, input logic [31:0] wd,
                          output int first_c, output int pulses,
                          output logic [31:0] d, output logic e, output logic [31:0] bvec);
    logic seen;
    seen = 1'b0; first_c = -1; pulses = 0; d = '0; e = 1'b0; bvec = '0;
    req[k] = 1'b1; addr[k] = a;
    for (int c = 1; c <= WIN; c++) begin
      @(posedge clk); #1;
      load_we = 1'b0;
      if (c == 1) addr[k] = $urandom;
      if (c == drop_c || seen) req[k] = 1'b0;
      if (c == wr_c) begin
        load_we = 1'b1; load_addr = wa; load_data = wd;
      end
      @(negedge clk);
      bvec[c] = bsy[k];
      if (resp[k]) begin
        pulses++;
        if (!seen) begin
          first_c = c; d = rdata[k]; e = err[k];
        end
        seen = 1'b1;
      end
    end
    req[k] = 1'b0; load_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; addr = '0; load_we = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (resp[k] !== 1'b0) begin n_fail++; $display("FAIL reset_resp[%0d]: got %b want 0", k, resp[k]); end
      n_checks++;
      if (rdata[k] !== 32'h0) begin n_fail++; $display("FAIL reset_data[%0d]: got %h want 0", k, rdata[k]); end
      n_checks++;
      if (bsy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", k, bsy[k]); end
      n_checks++;
      if (err[k] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b want 0", k, err[k]); end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    int fc, np; logic [31:0] d, bv, ea; logic e;
    load_word(32'h10, 32'hDEAD_BEEF);
    for (int i = 0; i < 12; i++) load_word({20'h0, 10'($urandom), 2'b00}, $urandom);
    for (int i = 0; i < NI + 9; i++) begin
      int k, lat;
      k = (i < NI) ? i : int'($urandom_range(0, NI - 1));
      lat = lat_of(k);
      ea = (i < NI) ? 32'h10 : pool_addr();
      run_read(k, ea, -1, -1, '0, '0, fc, np, d, e, bv);
      n_checks++;
      if (fc != lat) begin n_fail++; $display("FAIL latency[%0d]: got %0d want %0d", k, fc, lat); end
      n_checks++;
      if (np != 1) begin n_fail++; $display("FAIL pulse_count[%0d]: got %0d want 1", k, np); end
      n_checks++;
      if (d !== exp_read(ea)) begin n_fail++; $display("FAIL read_data[%0d] @%h: got %h want %h", k, ea, d, exp_read(ea)); end
      n_checks++;
      if (bv !== (((32'd1 << lat) - 32'd1) << 1)) begin
        n_fail++; $display("FAIL busy_window[%0d]: got %h want %h", k, bv, ((32'd1 << lat) - 32'd1) << 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < NI; k++) begin
      int lat, pc; logic adv; logic [31:0] al [4]; logic [31:0] el [4];
      lat = lat_of(k); pc = 0; adv = 1'b0;
      al[0] = 32'h0; al[1] = 32'h4; al[2] = pool_addr(); al[3] = pool_addr();
      for (int j = 0; j < 4; j++) el[j] = exp_read(al[j]);
      req[k] = 1'b1; addr[k] = al[0];
      for (int c = 1; c <= 4 * (lat + 1) + 6; c++) begin
        @(posedge clk); #1;
        if (adv) begin
          adv = 1'b0;
          if (pc < 4) addr[k] = al[pc];
          else req[k] = 1'b0;
        end
        @(negedge clk);
        if (resp[k]) begin
          if (pc < 4) begin
            n_checks++;
            if (c != lat + pc * (lat + 1)) begin
              n_fail++; $display("FAIL b2b_spacing[%0d] #%0d: got cycle %0d want %0d", k, pc, c, lat + pc * (lat + 1));
            end
            n_checks++;
            if (rdata[k] !== el[pc]) begin
              n_fail++; $display("FAIL b2b_data[%0d] #%0d: got %h want %h", k, pc, rdata[k], el[pc]);
            end
          end
          pc++; adv = 1'b1;
        end
      end
      req[k] = 1'b0;
      n_checks++;
      if (pc != 4) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want 4", k, pc); end
    end
  endtask

  task automatic test_abort();
    int fc, np; logic [31:0] d, bv, ea; logic e;
    for (int i = 0; i < 4; i++) begin
      int k, lat;
      k = (i == 0) ? 2 : int'($urandom_range(1, NI - 1));
      lat = lat_of(k);
      ea = (i == 0) ? 32'h10 : pool_addr();
      run_read(k, ea, 1, -1, '0, '0, fc, np, d, e, bv);
      n_checks++;
      if (fc != lat) begin n_fail++; $display("FAIL abort_latency[%0d]: got %0d want %0d", k, fc, lat); end
      n_checks++;
      if (np != 1) begin n_fail++; $display("FAIL abort_pulses[%0d]: got %0d want 1", k, np); end
      n_checks++;
      if (d !== exp_read(ea)) begin n_fail++; $display("FAIL abort_data[%0d]: got %h want %h", k, d, exp_read(ea)); end
    end
  endtask

  task automatic test_write_collision();
    int fc, np; logic [31:0] d, bv, ea, ed, wd; logic e;
    load_word(32'h20, 32'hA5A5_0001);
    for (int i = 0; i < 6; i++) begin
      int k, lat, wc;
      k = (i == 0) ? 1 : int'($urandom_range(1, NI - 1));
      lat = lat_of(k);
      ea = (i == 0) ? 32'h20 : pool_addr();
      wd = (i == 0) ? 32'h1234_5678 : $urandom;
      // even iterations write on the RESP-entry edge, odd ones on an earlier edge
      wc = (i % 2 == 0 || lat == 2) ? lat - 1 : lat - 2;
      ed = (wc == lat - 1) ? exp_read(ea) : wd;
      run_read(k, ea, -1, wc, ea, wd, fc, np, d, e, bv);
      model_write(ea, wd);
      n_checks++;
      if (d !== ed) begin n_fail++; $display("FAIL collide_data[%0d] wc=%0d: got %h want %h", k, wc, d, ed); end
      run_read(k, ea, -1, -1, '0, '0, fc, np, d, e, bv);
      n_checks++;
      if (d !== wd) begin n_fail++; $display("FAIL after_write[%0d]: got %h want %h", k, d, wd); end
    end
  endtask

  task automatic test_reset_wait();
    int fc, np; logic [31:0] d, bv; logic e;
    req[2] = 1'b1; addr[2] = 32'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (bsy[2] !== 1'b1) begin n_fail++; $display("FAIL wait_busy: got %b want 1", bsy[2]); end
    rst_n = 1'b0; req[2] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (resp[2] !== 1'b0) begin n_fail++; $display("FAIL rstwait_resp: got %b want 0", resp[2]); end
    n_checks++;
    if (rdata[2] !== 32'h0) begin n_fail++; $display("FAIL rstwait_data: got %h want 0", rdata[2]); end
    n_checks++;
    if (bsy[2] !== 1'b0) begin n_fail++; $display("FAIL rstwait_busy: got %b want 0", bsy[2]); end
    np = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (resp[2]) np++;
    end
    n_checks++;
    if (np != 0) begin n_fail++; $display("FAIL rstwait_pulses: got %0d want 0", np); end
    run_read(2, 32'h10, -1, -1, '0, '0, fc, np, d, e, bv);
    n_checks++;
    if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rstwait_preload: got %h want deadbeef", d); end
  endtask

  task automatic test_wrap();
    int fc, np; logic [31:0] d, bv; logic e;
    load_word(32'h4, $urandom);
    load_word(32'h48, 32'h0BAD_F00D);
    run_read(1, 32'h0000_1004, -1, -1, '0, '0, fc, np, d, e, bv);
    n_checks++;
    if (d !== exp_read(32'h0000_1004)) begin n_fail++; $display("FAIL wrap_data: got %h want %h", d, exp_read(32'h0000_1004)); end
    n_checks++;
    if (e !== addr_oob(32'h0000_1004)) begin n_fail++; $display("FAIL wrap_err: got %b want %b", e, addr_oob(32'h0000_1004)); end
    n_checks++;
    if (np != 1) begin n_fail++; $display("FAIL wrap_pulses: got %0d want 1", np); end
    load_word(32'h2000_0048, 32'h7777_1111);
    run_read(0, 32'h48, -1, -1, '0, '0, fc, np, d, e, bv);
    n_checks++;
    if (d !== exp_read(32'h48)) begin n_fail++; $display("FAIL wrap_write: got %h want %h", d, exp_read(32'h48)); end
    n_checks++;
    if (e !== 1'b0) begin n_fail++; $display("FAIL inrange_err: got %b want 0", e); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_abort();
    test_write_collision();
    test_reset_wait();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
